// File: rtl/melody_piezo_player.sv
// Piezo melody sequencer: latches NOTE_CNT period words on start and plays each for NOTE_TICKS
// cycles, followed by GAP_TICKS silent cycles. Optional MELODY_LOOP_EN adds a loop input.
module melody_piezo_player #(
    parameter  int DIV_W      = 12,
    parameter  int NOTE_CNT   = 4,
    parameter  int NOTE_TICKS = 5000000,
    parameter  int GAP_TICKS  = 500000,
    localparam int IDX_W      = (NOTE_CNT > 1) ? $clog2(NOTE_CNT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
`ifdef MELODY_LOOP_EN
    input  logic                      loop,
`endif
    input  logic [NOTE_CNT*DIV_W-1:0] melody,
    output logic                      piezo,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          note_idx
);
    localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
    localparam logic [DIV_W-2:0] TONE_ONE  = (DIV_W-1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NOTE_CNT - 1);
    localparam logic [DIV_W-1:0] REST_MAX  = DIV_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t                    r_state;
    logic [NOTE_CNT*DIV_W-1:0] r_melody;
    logic [IDX_W-1:0]          r_note_idx;
    logic [DIV_W-2:0]          r_tone;
    logic [DUR_W-1:0]          r_dur;
    logic                      r_piezo;
    logic                      r_busy;
    logic                      r_done;

    logic [DIV_W-1:0] w_words [NOTE_CNT];
    logic [DIV_W-1:0] w_limit;
    logic [DIV_W-2:0] w_half_m1;
    logic             w_rest;
    logic             w_last;
    logic             w_loop;

    // Note 0 sits in the most significant slice of the melody bus.
    always_comb begin
        for (int i = 0; i < NOTE_CNT; i++) begin
            w_words[i] = r_melody[(NOTE_CNT-1-i)*DIV_W +: DIV_W];
        end
    end

    assign w_limit   = w_words[r_note_idx];
    assign w_half_m1 = w_limit[DIV_W-1:1] - TONE_ONE;
    assign w_rest    = (w_limit <= REST_MAX);
    assign w_last    = (r_note_idx == IDX_LAST);

`ifdef MELODY_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_melody   <= '0;
            r_note_idx <= '0;
            r_tone     <= '0;
            r_dur      <= '0;
            r_piezo    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state    <= S_IDLE;
                r_note_idx <= '0;
                r_tone     <= '0;
                r_dur      <= '0;
                r_piezo    <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_piezo <= 1'b0;
                        if (start) begin
                            r_melody   <= melody;
                            r_note_idx <= '0;
                            r_tone     <= '0;
                            r_dur      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (r_dur == NOTE_LAST) begin
                            // Every note (or gap) begins with the pin low and a fresh tone phase.
                            r_dur   <= '0;
                            r_tone  <= '0;
                            r_piezo <= 1'b0;
                            if (GAP_TICKS > 0) begin
                                r_state <= S_GAP;
                            end else if (!w_last) begin
                                r_note_idx <= r_note_idx + IDX_ONE;
                            end else begin
                                r_note_idx <= '0;
                                if (!w_loop) begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end else begin
                            r_dur <= r_dur + DUR_ONE;
                            if (w_rest) begin
                                r_tone  <= '0;
                                r_piezo <= 1'b0;
                            end else if (r_tone == w_half_m1) begin
                                r_tone  <= '0;
                                r_piezo <= ~r_piezo;
                            end else begin
                                r_tone <= r_tone + TONE_ONE;
                            end
                        end
                    end
                    S_GAP: begin
                        r_piezo <= 1'b0;
                        r_tone  <= '0;
                        if (r_dur == GAP_LAST) begin
                            r_dur <= '0;
                            if (!w_last) begin
                                r_note_idx <= r_note_idx + IDX_ONE;
                                r_state    <= S_PLAY;
                            end else begin
                                r_note_idx <= '0;
                                if (w_loop) begin
                                    r_state <= S_PLAY;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end else begin
                            r_dur <= r_dur + DUR_ONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign piezo    = r_piezo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign note_idx = r_note_idx;
endmodule

// File: tb/tb_melody_piezo_player.sv
// Bench for melody_piezo_player: a gapped and a gap-less instance share stimulus; a closed-form
// per-cycle model fills one expected queue per instance. Define MELODY_LOOP_EN for the loop test.
module tb_melody_piezo_player;
    localparam int DIV_W    = 12;
    localparam int NOTE_CNT = 4;
    localparam int NT       = 100;
    localparam int GT       = 10;
    localparam int MW       = NOTE_CNT * DIV_W;
    localparam int NEVER    = 1000000;
    localparam logic [MW-1:0] MEL_A = {12'd8, 12'd0, 12'd4, 12'd2};

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [MW-1:0] melody = '0;
`ifdef MELODY_LOOP_EN
    logic          loop = 1'b0;
`endif
    logic          piezo, busy, done;
    logic [1:0]    note_idx;
    logic          piezo_ng, busy_ng, done_ng;
    logic [1:0]    note_idx_ng;

    // Vector layout: {busy, done, piezo, note_idx[1:0]}
    logic [4:0] exp_q[$];
    logic [4:0] exp_q_ng[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    melody_piezo_player #(.DIV_W(DIV_W), .NOTE_CNT(NOTE_CNT), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef MELODY_LOOP_EN
        .loop(loop),
`endif
        .melody(melody), .piezo(piezo), .busy(busy), .done(done), .note_idx(note_idx)
    );

    melody_piezo_player #(.DIV_W(DIV_W), .NOTE_CNT(NOTE_CNT), .NOTE_TICKS(NT), .GAP_TICKS(0)) dut_ng (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef MELODY_LOOP_EN
        .loop(loop),
`endif
        .melody(melody), .piezo(piezo_ng), .busy(busy_ng), .done(done_ng), .note_idx(note_idx_ng)
    );

    // Expected outputs t cycles after the accepting edge (t=0 is the first PLAY cycle).
    function automatic logic [4:0] model(input int t, input logic [MW-1:0] m, input int gt,
                                         input int tstop, input int nl);
        int per, total, note, p, half;
        logic [11:0] l;
        logic pz;
        per   = NT + gt;
        total = nl * NOTE_CNT * per;
        if (t >= tstop) return 5'b00000;
        if (t == total) return 5'b01000;
        if (t > total) return 5'b00000;
        t    = t % (NOTE_CNT * per);
        note = t / per;
        p    = t % per;
        l    = m[(NOTE_CNT-1-note)*DIV_W +: DIV_W];
        half = int'(l >> 1);
        pz   = 1'b0;
        if (p < NT && l >= 12'd2) pz = ((p / half) % 2) == 1;
        return {1'b1, 1'b0, pz, note[1:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor();
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if ({busy, done, piezo, note_idx} !== e) begin
                        n_err++;
                        $display("FAIL sb_gap at %0t: got %b required %b (busy,done,piezo,idx)",
                                 $time, {busy, done, piezo, note_idx}, e);
                    end
                end
                if (exp_q_ng.size() > 0) begin
                    e = exp_q_ng.pop_front();
                    n_vec++;
                    if ({busy_ng, done_ng, piezo_ng, note_idx_ng} !== e) begin
                        n_err++;
                        $display("FAIL sb_nogap at %0t: got %b required %b (busy,done,piezo,idx)",
                                 $time, {busy_ng, done_ng, piezo_ng, note_idx_ng}, e);
                    end
                end
            end
        end
    endtask

    // Drives a start request this cycle and queues the expected trace for both instances.
    task automatic launch(input logic [MW-1:0] m, input int len, input int tstop,
                          input int nl_gap, input int nl_ng);
        start  = 1'b1;
        melody = m;
        if (exp_q.size() == 0) exp_q.push_back(5'b00000);
        if (exp_q_ng.size() == 0) exp_q_ng.push_back(5'b00000);
        for (int t = 0; t < len; t++) begin
            exp_q.push_back(model(t, m, GT, tstop, nl_gap));
            exp_q_ng.push_back(model(t, m, 0, tstop, nl_ng));
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 3000;
        while ((exp_q.size() > 0 || exp_q_ng.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0 || exp_q_ng.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d entries left required 0",
                     exp_q.size(), exp_q_ng.size());
            exp_q.delete();
            exp_q_ng.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        n_vec++;
        if ({busy, done, piezo, note_idx} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_gap: got %b required 00000", {busy, done, piezo, note_idx});
        end
        n_vec++;
        if ({busy_ng, done_ng, piezo_ng, note_idx_ng} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_nogap: got %b required 00000", {busy_ng, done_ng, piezo_ng, note_idx_ng});
        end
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_play();
        cyc();
        launch(MEL_A, 0, NEVER, 1, 1);
        cyc();
        start = 1'b0;
        repeat (160) cyc();
        n_vec++;
        if ({busy, note_idx} !== 3'b101 || {busy_ng, note_idx_ng} !== 3'b101) begin
            n_err++;
            $display("FAIL pre_reset: got %b/%b required 101/101", {busy, note_idx}, {busy_ng, note_idx_ng});
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, piezo, note_idx} !== 5'b00000) begin
            n_err++;
            $display("FAIL async_reset_gap: got %b required 00000", {busy, done, piezo, note_idx});
        end
        n_vec++;
        if ({busy_ng, done_ng, piezo_ng, note_idx_ng} !== 5'b00000) begin
            n_err++;
            $display("FAIL async_reset_nogap: got %b required 00000", {busy_ng, done_ng, piezo_ng, note_idx_ng});
        end
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_play();
        cyc();
        launch(MEL_A, 446, NEVER, 1, 1);
        cyc();
        start = 1'b0;
        wait_drain();
    endtask

    task automatic test_ignore_restart();
        cyc();
        launch(MEL_A, 446, NEVER, 1, 1);
        cyc();
        start = 1'b0;
        repeat (50) cyc();
        start  = 1'b1;
        melody = MW'({$urandom(), $urandom()});
        cyc();
        start = 1'b0;
        repeat (200) cyc();
        melody = MW'({$urandom(), $urandom()});
        wait_drain();
    endtask

    task automatic test_stop();
        cyc();
        launch(MEL_A, 240, 230, 1, 1);
        cyc();
        start = 1'b0;
        repeat (229) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_drain();
        cyc();
        start = 1'b1;
        stop  = 1'b1;
        repeat (6) begin
            exp_q.push_back(5'b00000);
            exp_q_ng.push_back(5'b00000);
        end
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] m;
        m = {12'd6, 12'd3, 12'd1, 12'd10};
        cyc();
        launch(MEL_A, 441, NEVER, 1, 1);
        cyc();
        start = 1'b0;
        repeat (440) cyc();
        launch(m, 446, NEVER, 1, 1);
        cyc();
        start = 1'b0;
        wait_drain();
    endtask

    task automatic test_random();
        logic [MW-1:0] m;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < NOTE_CNT; j++) m[j*DIV_W +: DIV_W] = 12'($urandom_range(0, 12));
            cyc();
            launch(m, 446, NEVER, 1, 1);
            cyc();
            start = 1'b0;
            wait_drain();
        end
    endtask

`ifdef MELODY_LOOP_EN
    task automatic test_loop();
        cyc();
        loop = 1'b1;
        launch(MEL_A, 1606, NEVER, 3, 4);
        cyc();
        start = 1'b0;
        repeat (1220) cyc();
        loop = 1'b0;
        wait_drain();
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_reset_mid_play();
        test_play();
        test_ignore_restart();
        test_stop();
        test_back_to_back();
        test_random();
`ifdef MELODY_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
